// File: rtl/mem_sys_pkg.sv
// Shared types and helpers for the cache system-port front end.
package mem_sys_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } state_e;

   localparam int MAX_PORTS = 16;
   localparam int MAX_PW    = 4;

   function automatic int bval_w(input int word_width);
      return word_width / 8;
   endfunction

   function automatic logic [MAX_PORTS-1:0] onehot(input logic [MAX_PW-1:0] idx);
      return MAX_PORTS'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible port after rr_last, wrapping.
module rr_arbiter #(
   parameter int PORT_COUNT = 4,
   parameter int PORT_WIDTH = 2
) (
   input  logic [PORT_COUNT-1:0] elig,
   input  logic [PORT_WIDTH-1:0] rr_last,
   output logic [PORT_WIDTH-1:0] win,
   output logic                  win_vld
);

   always_comb begin
      logic [PORT_WIDTH-1:0] idx;
      idx     = '0;
      win     = '0;
      win_vld = 1'b0;
      // Walk the scan order backwards so the nearest eligible port lands last.
      for (int i = PORT_COUNT; i >= 1; i--) begin
         idx = PORT_WIDTH'((int'(rr_last) + i) % PORT_COUNT);
         if (elig[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin front end that shares the cache system port between PORT_COUNT requesters.
module cache_port_arbiter
   import mem_sys_pkg::*;
#(
   parameter  int ADDR_WIDTH     = 16,
   parameter  int WORD_WIDTH     = 32,
   parameter  int PORT_COUNT     = 4,
   parameter  int PORT_WIDTH     = 2,
   parameter  int TIMEOUT_CYCLES = 255,
   parameter  int TMO_WIDTH      = 8,
   localparam int BVAL_WIDTH     = bval_w(WORD_WIDTH)
) (
   input  logic                             cache_clk,
   input  logic                             rst,
   input  logic [PORT_COUNT*ADDR_WIDTH-1:0] port_addr,
   input  logic [PORT_COUNT*WORD_WIDTH-1:0] port_wdata,
   input  logic [PORT_COUNT*BVAL_WIDTH-1:0] port_bval,
   input  logic [PORT_COUNT-1:0]            port_rd,
   input  logic [PORT_COUNT-1:0]            port_wr,
   output logic [WORD_WIDTH-1:0]            port_rdata,
   output logic [PORT_COUNT-1:0]            port_ack,
   output logic                             port_err,
   output logic [ADDR_WIDTH-1:0]            cache_sys_addr,
   output logic [WORD_WIDTH-1:0]            cache_sys_wdata,
   output logic [BVAL_WIDTH-1:0]            cache_sys_bval,
   output logic                             cache_sys_rd,
   output logic                             cache_sys_wr,
   input  logic [WORD_WIDTH-1:0]            cache_sys_rdata,
   input  logic                             cache_sys_ack
);

   logic [PORT_COUNT-1:0][ADDR_WIDTH-1:0] addr_a;
   logic [PORT_COUNT-1:0][WORD_WIDTH-1:0] wdata_a;
   logic [PORT_COUNT-1:0][BVAL_WIDTH-1:0] bval_a;

   assign addr_a  = port_addr;
   assign wdata_a = port_wdata;
   assign bval_a  = port_bval;

   state_e                state_q, state_d;
   logic [PORT_WIDTH-1:0] rr_last_q, rr_last_d;
   logic [PORT_WIDTH-1:0] grant_q, grant_d;
   logic [PORT_COUNT-1:0] mask_q, mask_d;
   logic [TMO_WIDTH-1:0]  wdog_q, wdog_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
   logic [BVAL_WIDTH-1:0] bval_q, bval_d;
   logic                  sys_rd_q, sys_rd_d;
   logic                  sys_wr_q, sys_wr_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
   logic [PORT_COUNT-1:0] ack_q, ack_d;
   logic                  err_q, err_d;

   logic [PORT_COUNT-1:0] req, elig, grant_oh;
   logic [PORT_WIDTH-1:0] win;
   logic                  win_vld, win_illegal, wdog_expired;

   assign req          = port_rd | port_wr;
   assign elig         = req & ~mask_q;
   assign win_illegal  = port_rd[win] & port_wr[win];
   assign grant_oh     = PORT_COUNT'(onehot(MAX_PW'(grant_q)));
   assign wdog_expired = (TIMEOUT_CYCLES != 0) && (wdog_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1));

   rr_arbiter #(
      .PORT_COUNT (PORT_COUNT),
      .PORT_WIDTH (PORT_WIDTH)
   ) u_rr (
      .elig    (elig),
      .rr_last (rr_last_q),
      .win     (win),
      .win_vld (win_vld)
   );

   always_ff @(posedge cache_clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_last_q <= PORT_WIDTH'(PORT_COUNT - 1);
         grant_q   <= '0;
         mask_q    <= '0;
         wdog_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         bval_q    <= '0;
         sys_rd_q  <= 1'b0;
         sys_wr_q  <= 1'b0;
         rdata_q   <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         grant_q   <= grant_d;
         mask_q    <= mask_d;
         wdog_q    <= wdog_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         bval_q    <= bval_d;
         sys_rd_q  <= sys_rd_d;
         sys_wr_q  <= sys_wr_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_vld) state_d = win_illegal ? ERR : BUSY;
         BUSY:    if (cache_sys_ack || wdog_expired) state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rr_last_d = rr_last_q;
      grant_d   = grant_q;
      mask_d    = '0;
      wdog_d    = wdog_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      bval_d    = bval_q;
      sys_rd_d  = sys_rd_q;
      sys_wr_d  = sys_wr_q;
      rdata_d   = rdata_q;
      ack_d     = '0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               rr_last_d = win;
               grant_d   = win;
               addr_d    = addr_a[win];
               wdata_d   = wdata_a[win];
               bval_d    = bval_a[win];
               sys_rd_d  = port_rd[win] & ~win_illegal;
               sys_wr_d  = port_wr[win] & ~win_illegal;
               wdog_d    = '0;
            end
         end
         BUSY: begin
            // A cache ack landing on the timeout cycle still completes normally.
            if (cache_sys_ack) begin
               rdata_d  = cache_sys_rdata;
               ack_d    = grant_oh;
               mask_d   = grant_oh;
               sys_rd_d = 1'b0;
               sys_wr_d = 1'b0;
            end else if (wdog_expired) begin
               ack_d    = grant_oh;
               err_d    = 1'b1;
               mask_d   = grant_oh;
               sys_rd_d = 1'b0;
               sys_wr_d = 1'b0;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ERR: begin
            ack_d  = grant_oh;
            err_d  = 1'b1;
            mask_d = grant_oh;
         end
         default: ;
      endcase
   end

   assign port_rdata      = rdata_q;
   assign port_ack        = ack_q;
   assign port_err        = err_q;
   assign cache_sys_addr  = addr_q;
   assign cache_sys_wdata = wdata_q;
   assign cache_sys_bval  = bval_q;
   assign cache_sys_rd    = sys_rd_q;
   assign cache_sys_wr    = sys_wr_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed self-checking bench for cache_port_arbiter (4 ports, 8-cycle watchdog).
module tb_cache_port_arbiter;

   logic             cache_clk = 1'b0;
   logic             rst;
   logic [3:0][15:0] addr_a;
   logic [3:0][31:0] wdata_a;
   logic [3:0][3:0]  bval_a;
   logic [3:0]       rd, wr;
   logic [31:0]      port_rdata;
   logic [3:0]       port_ack;
   logic             port_err;
   logic [15:0]      cache_sys_addr;
   logic [31:0]      cache_sys_wdata;
   logic [3:0]       cache_sys_bval;
   logic             cache_sys_rd, cache_sys_wr;
   logic [31:0]      cache_sys_rdata;
   logic             cache_sys_ack;

   int total = 0;
   int bad   = 0;

   cache_port_arbiter #(
      .ADDR_WIDTH     (16),
      .WORD_WIDTH     (32),
      .PORT_COUNT     (4),
      .PORT_WIDTH     (2),
      .TIMEOUT_CYCLES (8),
      .TMO_WIDTH      (8)
   ) dut (
      .cache_clk       (cache_clk),
      .rst             (rst),
      .port_addr       (addr_a),
      .port_wdata      (wdata_a),
      .port_bval       (bval_a),
      .port_rd         (rd),
      .port_wr         (wr),
      .port_rdata      (port_rdata),
      .port_ack        (port_ack),
      .port_err        (port_err),
      .cache_sys_addr  (cache_sys_addr),
      .cache_sys_wdata (cache_sys_wdata),
      .cache_sys_bval  (cache_sys_bval),
      .cache_sys_rd    (cache_sys_rd),
      .cache_sys_wr    (cache_sys_wr),
      .cache_sys_rdata (cache_sys_rdata),
      .cache_sys_ack   (cache_sys_ack)
   );

   always #5 cache_clk = ~cache_clk;

   task automatic tick();
      @(posedge cache_clk);
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      rd              = '0;
      wr              = '0;
      addr_a          = '0;
      wdata_a         = '0;
      bval_a          = '0;
      cache_sys_ack   = 1'b0;
      cache_sys_rdata = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      rd  = 4'b0010;
      tick();
      total++;
      if ({cache_sys_rd, cache_sys_wr, port_ack, port_err} !== 7'd0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 0", {cache_sys_rd, cache_sys_wr, port_ack, port_err});
      end
      total++;
      if ({cache_sys_addr, cache_sys_wdata, cache_sys_bval, port_rdata} !== 84'd0) begin
         bad++;
         $display("FAIL reset_data: got %h want 0", {cache_sys_addr, cache_sys_wdata, cache_sys_bval, port_rdata});
      end
      rd  = '0;
      rst = 1'b0;
   endtask

   task automatic test_read();
      do_reset();
      addr_a[2] = 16'h1234;
      rd[2]     = 1'b1;
      tick();
      total++;
      if ({cache_sys_rd, cache_sys_wr} !== 2'b10) begin
         bad++;
         $display("FAIL read_strobe: got %b want 10", {cache_sys_rd, cache_sys_wr});
      end
      total++;
      if (cache_sys_addr !== 16'h1234) begin
         bad++;
         $display("FAIL read_addr: got %h want 1234", cache_sys_addr);
      end
      tick();
      tick();
      tick();
      total++;
      if (port_ack !== 4'b0000 || cache_sys_rd !== 1'b1) begin
         bad++;
         $display("FAIL read_wait: ack %b rd %b want 0000 1", port_ack, cache_sys_rd);
      end
      cache_sys_ack   = 1'b1;
      cache_sys_rdata = 32'hDEADBEEF;
      tick();
      cache_sys_ack = 1'b0;
      total++;
      if (port_ack !== 4'b0100 || port_err !== 1'b0) begin
         bad++;
         $display("FAIL read_ack: got %b/%b want 0100/0", port_ack, port_err);
      end
      total++;
      if (port_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL read_data: got %h want deadbeef", port_rdata);
      end
      total++;
      if (cache_sys_rd !== 1'b0) begin
         bad++;
         $display("FAIL read_strobe_drop: got %b want 0", cache_sys_rd);
      end
      rd[2] = 1'b0;
      cache_sys_rdata = 32'h11112222;
      tick();
      total++;
      if (port_ack !== 4'b0000 || port_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL read_hold: ack %b data %h want 0000 deadbeef", port_ack, port_rdata);
      end
   endtask

   task automatic test_round_robin();
      int         exp_order[5] = '{0, 1, 2, 3, 0};
      int         n    = 0;
      int         last = -1;
      logic [3:0] drop = '0;
      logic [3:0] rearm = '0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         addr_a[i]  = 16'h0100 + 16'(i);
         wdata_a[i] = 32'hA5A50000 | 32'(i);
         bval_a[i]  = 4'(1 << i);
      end
      wr = 4'hF;
      for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
         tick();
         // requesters drop the cycle after seeing their ack, then re-request
         wr    = (wr | rearm) & ~drop;
         rearm = drop;
         drop  = port_ack;
         cache_sys_ack = cache_sys_wr;
         if (port_ack !== 4'b0000) begin
            total++;
            if (last < 0 || port_ack !== 4'(1 << last) || port_err !== 1'b0) begin
               bad++;
               $display("FAIL rr_ack: got %b/%b want onehot(%0d)/0", port_ack, port_err, last);
            end
         end
         if (cache_sys_wr === 1'b1) begin
            total++;
            if (cache_sys_wdata !== (32'hA5A50000 | 32'(exp_order[n])) ||
                cache_sys_bval  !== 4'(1 << exp_order[n]) ||
                cache_sys_addr  !== 16'h0100 + 16'(exp_order[n])) begin
               bad++;
               $display("FAIL rr_grant%0d: got %h/%b/%h want port %0d", n, cache_sys_wdata,
                        cache_sys_bval, cache_sys_addr, exp_order[n]);
            end
            last = exp_order[n];
            n++;
         end
      end
      total++;
      if (n !== 5) begin
         bad++;
         $display("FAIL rr_count: got %0d grants want 5", n);
      end
      wr = '0;
      cache_sys_ack = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_mask();
      do_reset();
      addr_a[1] = 16'h0111;
      addr_a[3] = 16'h0333;
      rd[1]     = 1'b1;
      tick();
      cache_sys_ack = 1'b1;
      tick();
      cache_sys_ack = 1'b0;
      total++;
      if (port_ack !== 4'b0010) begin
         bad++;
         $display("FAIL mask_ack1: got %b want 0010", port_ack);
      end
      tick();
      total++;
      if (cache_sys_rd !== 1'b0) begin
         bad++;
         $display("FAIL mask_regrant: got rd %b addr %h want 0", cache_sys_rd, cache_sys_addr);
      end
      rd[1] = 1'b0;
      rd[3] = 1'b1;
      tick();
      total++;
      if (cache_sys_rd !== 1'b1 || cache_sys_addr !== 16'h0333) begin
         bad++;
         $display("FAIL mask_next: got %b/%h want 1/0333", cache_sys_rd, cache_sys_addr);
      end
      cache_sys_ack = 1'b1;
      tick();
      cache_sys_ack = 1'b0;
      total++;
      if (port_ack !== 4'b1000) begin
         bad++;
         $display("FAIL mask_ack3: got %b want 1000", port_ack);
      end
      rd[3] = 1'b0;
      tick();
   endtask

   task automatic test_illegal();
      do_reset();
      rd[0] = 1'b1;
      wr[0] = 1'b1;
      cache_sys_rdata = 32'hBAD0BAD0;
      tick();
      cache_sys_ack = 1'b1;
      total++;
      if ({cache_sys_rd, cache_sys_wr, port_ack} !== 6'd0) begin
         bad++;
         $display("FAIL illegal_nostrobe: got %b want 0", {cache_sys_rd, cache_sys_wr, port_ack});
      end
      tick();
      cache_sys_ack = 1'b0;
      total++;
      if (port_ack !== 4'b0001 || port_err !== 1'b1) begin
         bad++;
         $display("FAIL illegal_ack: got %b/%b want 0001/1", port_ack, port_err);
      end
      rd[0] = 1'b0;
      wr[0] = 1'b0;
      tick();
      cache_sys_ack = 1'b1;
      tick();
      cache_sys_ack = 1'b0;
      total++;
      if (port_ack !== 4'b0000 || port_err !== 1'b0 || port_rdata !== 32'd0) begin
         bad++;
         $display("FAIL stray_ack: got %b/%b/%h want 0000/0/0", port_ack, port_err, port_rdata);
      end
   endtask

   task automatic test_timeout();
      int hi = 0;
      do_reset();
      addr_a[1] = 16'h0011;
      rd[1]     = 1'b1;
      tick();
      cache_sys_ack   = 1'b1;
      cache_sys_rdata = 32'h5555AAAA;
      tick();
      cache_sys_ack   = 1'b0;
      cache_sys_rdata = 32'h0BADF00D;
      rd[1]           = 1'b0;
      tick();
      addr_a[2] = 16'h0022;
      wr[2]     = 1'b1;
      tick();
      while (cache_sys_wr === 1'b1 && hi < 20) begin
         hi++;
         tick();
      end
      total++;
      if (hi !== 8) begin
         bad++;
         $display("FAIL tmo_len: got %0d busy cycles want 8", hi);
      end
      total++;
      if (port_ack !== 4'b0100 || port_err !== 1'b1) begin
         bad++;
         $display("FAIL tmo_ack: got %b/%b want 0100/1", port_ack, port_err);
      end
      total++;
      if (port_rdata !== 32'h5555AAAA) begin
         bad++;
         $display("FAIL tmo_rdata: got %h want 5555aaaa", port_rdata);
      end
      wr[2] = 1'b0;
      tick();
      addr_a[3] = 16'h0033;
      rd[3]     = 1'b1;
      tick();
      repeat (7) tick();
      cache_sys_ack   = 1'b1;
      cache_sys_rdata = 32'hCAFEF00D;
      tick();
      cache_sys_ack = 1'b0;
      total++;
      if (port_ack !== 4'b1000 || port_err !== 1'b0 || port_rdata !== 32'hCAFEF00D) begin
         bad++;
         $display("FAIL tmo_ack_wins: got %b/%b/%h want 1000/0/cafef00d", port_ack, port_err, port_rdata);
      end
      rd[3] = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      addr_a[2] = 16'h0222;
      rd[2]     = 1'b1;
      tick();
      total++;
      if (cache_sys_rd !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre: got %b want 1", cache_sys_rd);
      end
      rst           = 1'b1;
      cache_sys_ack = 1'b1;
      tick();
      cache_sys_ack = 1'b0;
      rst           = 1'b0;
      total++;
      if ({cache_sys_rd, cache_sys_wr, port_ack, port_err, cache_sys_addr} !== 23'd0) begin
         bad++;
         $display("FAIL mid_reset: got %h want 0", {cache_sys_rd, cache_sys_wr, port_ack, port_err, cache_sys_addr});
      end
      for (int i = 0; i < 4; i++) addr_a[i] = 16'h0A00 + 16'(i);
      rd = 4'hF;
      tick();
      total++;
      if (cache_sys_rd !== 1'b1 || cache_sys_addr !== 16'h0A00 || port_ack !== 4'b0000) begin
         bad++;
         $display("FAIL mid_first: got %b/%h/%b want 1/0a00/0000", cache_sys_rd, cache_sys_addr, port_ack);
      end
      cache_sys_ack = 1'b1;
      tick();
      cache_sys_ack = 1'b0;
      total++;
      if (port_ack !== 4'b0001) begin
         bad++;
         $display("FAIL mid_ack: got %b want 0001", port_ack);
      end
      rd = '0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_read();
      test_round_robin();
      test_mask();
      test_illegal();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Multi-requester front end for the cache's system port. Replaces the single-CPU interface path with PORT_COUNT requester ports sharing one cache.
- Round-robin arbitration; the winning request's address, data and byte lanes are latched and issued to the cache.
- Waits for the cache ack, returns read data and a one-cycle ack to the winner.
- Adds a protocol-error check and a watchdog timeout.

Parameters:
ADDR_WIDTH, 16, system address width
WORD_WIDTH, 32, data word width; BVAL_WIDTH = WORD_WIDTH/8 (localparam)
PORT_COUNT, 4, number of requester ports (2..16)
PORT_WIDTH, 2, log2(PORT_COUNT)
TIMEOUT_CYCLES, 255, max BUSY cycles before abort; 0 disables the watchdog
TMO_WIDTH, 8, width of the watchdog counter (must hold TIMEOUT_CYCLES)

Ports:
cache_clk  in  1  single clock for the whole block
rst  in  1  synchronous, active-high reset
port_addr  in  PORT_COUNT*ADDR_WIDTH  per-port address, port i at slice i
port_wdata  in  PORT_COUNT*WORD_WIDTH  per-port write data
port_bval  in  PORT_COUNT*BVAL_WIDTH  per-port byte-lane enables
port_rd  in  PORT_COUNT  per-port read request
port_wr  in  PORT_COUNT  per-port write request
port_rdata  out  WORD_WIDTH  shared read-data return, valid with port_ack
port_ack  out  PORT_COUNT  one-hot, one-cycle completion pulse
port_err  out  1  qualifies port_ack: request aborted or illegal
cache_sys_addr  out  ADDR_WIDTH  latched address to cache
cache_sys_wdata  out  WORD_WIDTH  latched write data
cache_sys_bval  out  BVAL_WIDTH  latched byte lanes
cache_sys_rd  out  1  cache read strobe, level, held until ack
cache_sys_wr  out  1  cache write strobe, level, held until ack
cache_sys_rdata  in  WORD_WIDTH  cache read data
cache_sys_ack  in  1  cache completion pulse

Behaviour:
- Clock and reset: one clock, cache_clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; rr_last = PORT_COUNT-1, so port 0 has top priority first; mask_q = 0; watchdog counter = 0.
- Reset mid-operation: the transaction is dropped and no port_ack is issued. The cache strobes fall on the reset edge.
- Requester rule: req_i = port_rd[i] | port_wr[i]. The requester holds the request and its data stable until it sees port_ack[i], then deasserts next cycle.
- Eligibility: elig = req & ~mask_q.
  - mask_q is the one-hot of the port acked in the previous cycle, cleared after one cycle.
  - This prevents re-granting a requester that has not yet dropped its request.
- Arbitration: the winner is the first eligible port scanning rr_last+1, rr_last+2, … modulo PORT_COUNT.
- IDLE, elig != 0:
  - Latch the winner's addr/wdata/bval/op into grant registers; rr_last <= winner.
  - If port_rd & port_wr are both high on the winner: go to ERR. The cache is not touched.
  - Otherwise: go to BUSY, setting cache_sys_rd/wr on the same edge. The cache sees the request 1 cycle after the request is first visible.
- BUSY: cache outputs are held constant; the watchdog increments each cycle.
  - cache_sys_ack: port_rdata <= cache_sys_rdata (writes also load it; value unspecified to requester); port_ack[grant] <= 1; port_err <= 0; cache strobes <= 0; mask_q <= onehot(grant); go to IDLE.
  - Watchdog reaches TIMEOUT_CYCLES (nonzero) without ack: abort. Strobes <= 0, port_ack[grant] <= 1, port_err <= 1, port_rdata unchanged, go to IDLE.
  - A cache ack in the same cycle as the timeout wins: normal completion, no error.
- ERR (1 cycle): port_ack[grant] <= 1, port_err <= 1, mask_q set, go to IDLE.
- port_ack and port_err are single-cycle pulses. port_rdata holds its value until the next successful completion.
- Minimum turnaround is 3 cycles (IDLE→BUSY→ack→IDLE). A cache ack arriving in cycle k gives port_ack in cycle k+1.
- A cache_sys_ack in IDLE or ERR is ignored.
- Request changes on non-granted ports during BUSY are permitted. Only the latched copy is used.

Decomposition:
- Package mem_sys_pkg holds:
  - state enum {IDLE, BUSY, ERR}
  - localparam BVAL_WIDTH derivation
  - function onehot(PORT_WIDTH)
- One sub-module, rr_arbiter: combinational winner select from elig and rr_last, parametrised by PORT_COUNT/PORT_WIDTH.
- The FSM, grant registers and watchdog stay in cache_port_arbiter.

Test Plan:
- Reset, then port 2 reads addr 0x1234; the cache acks 3 cycles after the strobe with 0xDEADBEEF → cache_sys_rd is high 1 cycle after the request; port_ack = 4'b0100 and port_rdata = 0xDEADBEEF one cycle after the cache ack; port_err = 0.
- Ports 0–3 all write and hold their requests; the cache acks immediately each time → grant order 0,1,2,3,0; cache_sys_wdata/bval match each port's values; no port is granted twice in a row.
- Port 1 requests, is acked, and keeps its request high one extra cycle (compliant drop) → port 1 is not re-granted in the masked cycle; port 3, pending, wins next.
- Port 0 asserts rd and wr together → no cache strobe; port_ack = 4'b0001 with port_err = 1, two cycles after the request.
- TIMEOUT_CYCLES = 8 and the cache never acks → strobes drop after 8 BUSY cycles; port_ack pulses with port_err = 1; a subsequent request from another port completes normally.
- rst asserted during BUSY → all outputs 0 the next cycle, no port_ack; rr_last restored so port 0 wins the first post-reset contention.
